// File: rtl/cellrv32_sysinfo_ext.sv
// ---------------------------------------------------------------------------
// cellrv32_sysinfo_ext
// Second-generation system information unit for the CELLRV32 IO space.
// Occupies a 128-byte window at BASE_ADDR and answers every decoded strobe
// with exactly one ack_o or err_o pulse in the following cycle.
//
// Word map (word index = addr_i[6:2]):
//   0..INFO_WORDS-1        INFO       read-only words taken from info_i
//   16                     CTRL       bit0 lock (set-only), bit1 uptime clear
//   17                     UPTIME_LO  live counter[31:0], snapshots [63:32]
//   18                     UPTIME_HI  snapshot taken by the last LO read
//   24..24+NUM_SCRATCH-1   SCRATCH    byte-writable while lock = 0
//
// Optional feature macro: CELLRV32_SYSINFO_UPTIME_EN
//   defined   - 64-bit uptime counter, its HI shadow and CTRL bit1 exist
//   undefined - no counter flops; UPTIME_LO/HI read 0, CTRL bit1 ignored
//
// Ports:
//   clk_i   global clock
//   rst_i   synchronous, active-high reset
//   addr_i  bus address          rden_i / wren_i  read / write strobes
//   ben_i   write byte enables   data_i           write data
//   info_i  INFO_WORDS x 32-bit static configuration words
//   data_o  read data (zero unless ack_o)
//   ack_o   transfer acknowledge err_o            transfer error
// ---------------------------------------------------------------------------
module cellrv32_sysinfo_ext #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFFFE00,
  parameter int          INFO_WORDS  = 8,
  parameter int          NUM_SCRATCH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               addr_i,
  input  logic                      rden_i,
  input  logic                      wren_i,
  input  logic [3:0]                ben_i,
  input  logic [31:0]               data_i,
  input  logic [32*INFO_WORDS-1:0]  info_i,
  output logic [31:0]               data_o,
  output logic                      ack_o,
  output logic                      err_o
);

  // Keep a one-entry array when no scratch registers are configured so the
  // declarations stay legal; hit_scr never asserts in that case.
  localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

  localparam logic [4:0] W_CTRL  = 5'd16;
  localparam logic [4:0] W_UP_LO = 5'd17;
  localparam logic [4:0] W_UP_HI = 5'd18;
  localparam logic [4:0] W_SCR0  = 5'd24;

  logic        acc_en;
  logic [4:0]  word;
  logic        hit_info, hit_ctrl, hit_lo, hit_hi, hit_scr;
  logic        rd_req, wr_req, rd_ok;
  logic        wr_ctrl, wr_scr;
  logic        resp_ack, resp_err;
  logic [31:0] rd_data;
  logic [31:0] up_lo, up_hi;
  logic        lock_q;
  logic [31:0] scratch_q [SCR_N];

  // Byte offset bits are irrelevant for a word-wide slave.
  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];

  // ---------------------------------------------------------------- decode
  assign acc_en   = (addr_i[31:7] == BASE_ADDR[31:7]);
  assign word     = addr_i[6:2];
  assign hit_info = int'(word) < INFO_WORDS;
  assign hit_ctrl = (word == W_CTRL);
  assign hit_lo   = (word == W_UP_LO);
  assign hit_hi   = (word == W_UP_HI);
  assign hit_scr  = (word >= W_SCR0) && (int'(word - W_SCR0) < NUM_SCRATCH);

  // A strobe with both rden_i and wren_i is neither a read nor a write; it
  // falls through to the error response below.
  assign rd_req   = acc_en & rden_i & ~wren_i;
  assign wr_req   = acc_en & wren_i & ~rden_i;
  assign wr_ctrl  = wr_req & hit_ctrl;
  assign wr_scr   = wr_req & hit_scr & ~lock_q;
  assign resp_ack = (rd_req & rd_ok) | wr_ctrl | wr_scr;
  assign resp_err = acc_en & (rden_i | wren_i) & ~resp_ack;

  // ---------------------------------------------------------- read mux
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rd_data = '0;
    rd_ok   = hit_info | hit_ctrl | hit_lo | hit_hi | hit_scr;
    for (int k = 0; k < INFO_WORDS; k++) begin
      if (hit_info && (word == k[4:0])) rd_data = info_i[32*k +: 32];
    end
    if (hit_ctrl) rd_data = {31'd0, lock_q};  // clear bit reads back 0
    if (hit_lo)   rd_data = up_lo;
    if (hit_hi)   rd_data = up_hi;
    for (int i = 0; i < SCR_N; i++) begin
      if (hit_scr && (word[2:0] == i[2:0])) rd_data = scratch_q[i];
    end
  end

  // ------------------------------------------------- response and state
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      data_o <= '0;
      lock_q <= 1'b0;
      // NOTE: the scratch file is small and its reset contents are
      // software-visible, so it is reset like ordinary flops rather than
      // being treated as an unreset RAM.
      for (int i = 0; i < SCR_N; i++) scratch_q[i] <= '0;
    end else begin
      ack_o  <= resp_ack;
      err_o  <= resp_err;
      data_o <= (rd_req && rd_ok) ? rd_data : '0;
      if (wr_ctrl) lock_q <= lock_q | data_i[0];  // sticky until reset
      if (wr_scr) begin
        for (int i = 0; i < SCR_N; i++) begin
          for (int b = 0; b < 4; b++) begin
            if ((word[2:0] == i[2:0]) && ben_i[b])
              scratch_q[i][8*b +: 8] <= data_i[8*b +: 8];
          end
        end
      end
    end
  end

  // ------------------------------------------------------- uptime counter
`ifdef CELLRV32_SYSINFO_UPTIME_EN
  logic [63:0] uptime_q;
  logic [31:0] shadow_q;
  logic        up_clr;
  logic        lo_read;

  assign up_clr  = wr_ctrl & data_i[1];
  assign lo_read = rd_req & hit_lo;

  // Reading LO captures the upper half from the same cycle, so a following
  // HI read returns a value consistent with the LO just returned.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      uptime_q <= '0;
      shadow_q <= '0;
    end else if (up_clr) begin
      uptime_q <= '0;               // clear wins over the increment
      shadow_q <= '0;
    end else begin
      uptime_q <= uptime_q + 64'd1;
      if (lo_read) shadow_q <= uptime_q[63:32];
    end
  end

  assign up_lo = uptime_q[31:0];
  assign up_hi = shadow_q;
`else
  assign up_lo = '0;
  assign up_hi = '0;
`endif

endmodule

// File: tb/tb_cellrv32_sysinfo_ext.sv
// ---------------------------------------------------------------------------
// tb_cellrv32_sysinfo_ext
// Self-checking bench for cellrv32_sysinfo_ext: directed scenarios followed by
// randomized bus traffic, every response compared against a behavioural model
// of the register map (info words, lock bit, scratch words).
// Uptime values are checked with directed constants; the directed block
// follows CELLRV32_SYSINFO_UPTIME_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_cellrv32_sysinfo_ext;

  localparam logic [31:0] BASE        = 32'hFFFFFE00;
  localparam int          INFO_WORDS  = 8;
  localparam int          NUM_SCRATCH = 4;
`ifdef CELLRV32_SYSINFO_UPTIME_EN
  localparam bit          UPTIME_EN   = 1'b1;
`else
  localparam bit          UPTIME_EN   = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_i;
  logic [31:0]              addr_i;
  logic                     rden_i, wren_i;
  logic [3:0]               ben_i;
  logic [31:0]              data_i;
  logic [32*INFO_WORDS-1:0] info_i;
  logic [31:0]              data_o;
  logic                     ack_o, err_o;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  logic [31:0] m_info [INFO_WORDS];
  logic [31:0] m_scr  [NUM_SCRATCH];
  bit          m_lock;

  // results of the most recent bus transfer
  logic        last_ack, last_err;
  logic [31:0] last_rd;

  cellrv32_sysinfo_ext #(
    .BASE_ADDR  (BASE),
    .INFO_WORDS (INFO_WORDS),
    .NUM_SCRATCH(NUM_SCRATCH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .addr_i(addr_i),
    .rden_i(rden_i),
    .wren_i(wren_i),
    .ben_i (ben_i),
    .data_i(data_i),
    .info_i(info_i),
    .data_o(data_o),
    .ack_o (ack_o),
    .err_o (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0;
    for (int i = 0; i < NUM_SCRATCH; i++) m_scr[i] = '0;
  endtask

  // Expected response for one strobe, derived from the register map rules.
  task automatic model(input logic [31:0] a, input bit rd, input bit wr,
                       input logic [3:0] be, input logic [31:0] d,
                       output logic ack, output logic err, output logic [31:0] rdat);
    int w;
    w    = int'(a[6:2]);
    ack  = 1'b0;
    err  = 1'b0;
    rdat = '0;
    if (a[31:7] != BASE[31:7] || !(rd || wr)) return;
    if (rd && wr) begin
      err = 1'b1;
      return;
    end
    if (rd) begin
      if (w < INFO_WORDS)                           begin ack = 1'b1; rdat = m_info[w]; end
      else if (w == 16)                             begin ack = 1'b1; rdat = {31'd0, m_lock}; end
      else if (w == 17 || w == 18)                  begin ack = 1'b1; rdat = '0; end
      else if (w >= 24 && w < 24 + NUM_SCRATCH)     begin ack = 1'b1; rdat = m_scr[w-24]; end
      else                                          err = 1'b1;
    end else begin
      if (w == 16) begin
        ack    = 1'b1;
        m_lock = m_lock | d[0];
      end else if (w >= 24 && w < 24 + NUM_SCRATCH && !m_lock) begin
        ack = 1'b1;
        for (int b = 0; b < 4; b++)
          if (be[b]) m_scr[w-24][8*b +: 8] = d[8*b +: 8];
      end else begin
        err = 1'b1;
      end
    end
  endtask

  // Present one strobe for one cycle and capture the response after the edge.
  task automatic bus(input logic [31:0] a, input bit rd, input bit wr,
                     input logic [3:0] be, input logic [31:0] d);
    addr_i = a;
    rden_i = rd;
    wren_i = wr;
    ben_i  = be;
    data_i = d;
    @(posedge clk);
    #1;
    last_ack = ack_o;
    last_err = err_o;
    last_rd  = data_o;
    rden_i   = 1'b0;
    wren_i   = 1'b0;
  endtask

  task automatic access(input string tag, input logic [31:0] a, input bit rd, input bit wr,
                        input logic [3:0] be, input logic [31:0] d);
    logic        ea, ee;
    logic [31:0] ed;
    model(a, rd, wr, be, d, ea, ee, ed);
    bus(a, rd, wr, be, d);
    check({tag, " ack"},  {31'd0, last_ack}, {31'd0, ea});
    check({tag, " err"},  {31'd0, last_err}, {31'd0, ee});
    check({tag, " data"}, last_rd, ed);
  endtask

  initial begin
    rst_i  = 1'b1;
    rden_i = 1'b0;
    wren_i = 1'b0;
    addr_i = '0;
    ben_i  = '0;
    data_i = '0;
    for (int k = 0; k < INFO_WORDS; k++) m_info[k] = $urandom;
    m_info[3] = 32'hCAFE0003;
    for (int k = 0; k < INFO_WORDS; k++) info_i[32*k +: 32] = m_info[k];
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset ack",  {31'd0, ack_o}, 32'd0);
    check("reset err",  {31'd0, err_o}, 32'd0);
    check("reset data", data_o, 32'd0);
    rst_i = 1'b0;

    // info words
    access("info3 read", BASE + 32'h0C, 1'b1, 1'b0, 4'h0, '0);
    check("info3 value", last_rd, 32'hCAFE0003);
    access("info8 unmapped read", BASE + 32'h20, 1'b1, 1'b0, 4'h0, '0);
    check("info8 err", {31'd0, last_err}, 32'd1);

    // partial scratch write
    access("scr0 write lanes01", BASE + 32'h60, 1'b0, 1'b1, 4'b0011, 32'h12345678);
    access("scr0 readback", BASE + 32'h60, 1'b1, 1'b0, 4'h0, '0);
    check("scr0 value", last_rd, 32'h00005678);

    // error cases
    access("info write", BASE + 32'h00, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF);
    check("info write err", {31'd0, last_err}, 32'd1);
    access("rd+wr scr0", BASE + 32'h60, 1'b1, 1'b1, 4'hF, 32'hFFFFFFFF);
    access("scr0 after rd+wr", BASE + 32'h60, 1'b1, 1'b0, 4'h0, '0);
    check("scr0 unchanged", last_rd, 32'h00005678);
    access("outside window", BASE + 32'h80, 1'b1, 1'b0, 4'h0, '0);

    // uptime
`ifdef CELLRV32_SYSINFO_UPTIME_EN
    force dut.uptime_q = 64'h00000001_FFFFFFFE;
    bus(BASE + 32'h44, 1'b1, 1'b0, 4'h0, '0);
    release dut.uptime_q;
    check("uptime lo ack", {31'd0, last_ack}, 32'd1);
    check("uptime lo snap", last_rd, 32'hFFFFFFFE);
    @(posedge clk);
    #1;
    bus(BASE + 32'h48, 1'b1, 1'b0, 4'h0, '0);
    check("uptime hi ack", {31'd0, last_ack}, 32'd1);
    check("uptime hi shadow", last_rd, 32'd1);
    access("ctrl clear", BASE + 32'h40, 1'b0, 1'b1, 4'hF, 32'd2);
    @(posedge clk);
    #1;
    bus(BASE + 32'h44, 1'b1, 1'b0, 4'h0, '0);
    check("uptime after clear", last_rd, 32'd1);
`else
    access("uptime lo off", BASE + 32'h44, 1'b1, 1'b0, 4'h0, '0);
    access("uptime hi off", BASE + 32'h48, 1'b1, 1'b0, 4'h0, '0);
    access("ctrl clear off", BASE + 32'h40, 1'b0, 1'b1, 4'hF, 32'd2);
    @(posedge clk);
    #1;
    access("uptime lo after clear off", BASE + 32'h44, 1'b1, 1'b0, 4'h0, '0);
    check("uptime lo off value", last_rd, 32'd0);
`endif
    access("ctrl readback", BASE + 32'h40, 1'b1, 1'b0, 4'h0, '0);
    access("uptime lo write", BASE + 32'h44, 1'b0, 1'b1, 4'hF, 32'h1);
    access("uptime hi write", BASE + 32'h48, 1'b0, 1'b1, 4'hF, 32'h1);

    // randomized traffic, back-to-back strobes
    for (int n = 0; n < 300; n++) begin
      logic [4:0]  w;
      logic [31:0] a, d;
      bit          rd, wr;
      int          op, where;
      w = 5'($urandom_range(0, 31));
      // live counter values are covered by directed checks only
      if (UPTIME_EN && (w == 5'd17 || w == 5'd18)) w = 5'd24;
      a     = BASE | {25'd0, w, 2'($urandom)};
      where = $urandom_range(0, 19);
      if (where == 0) a = a + 32'h80;
      else if (where == 1) a = $urandom;
      op = $urandom_range(0, 9);
      rd = (op <= 5);
      wr = (op == 0) || (op >= 6);
      d  = $urandom;
      if (w == 5'd16 && $urandom_range(0, 15) != 0) d[0] = 1'b0;
      access("random", a, rd, wr, 4'($urandom), d);
    end

    // lock behaviour
    access("lock set", BASE + 32'h40, 1'b0, 1'b1, 4'h0, 32'd1);
    access("locked scr write", BASE + 32'h60, 1'b0, 1'b1, 4'hF, 32'hA5A5A5A5);
    check("locked scr err", {31'd0, last_err}, 32'd1);
    access("locked scr read", BASE + 32'h60, 1'b1, 1'b0, 4'h0, '0);
    access("lock clear attempt", BASE + 32'h40, 1'b0, 1'b1, 4'hF, 32'd0);
    access("lock sticky", BASE + 32'h40, 1'b1, 1'b0, 4'h0, '0);
    check("lock still set", last_rd, 32'd1);

    // reset coincident with a strobe
    rst_i  = 1'b1;
    addr_i = BASE + 32'h0C;
    rden_i = 1'b1;
    @(posedge clk);
    #1;
    rden_i = 1'b0;
    check("rst strobe ack",  {31'd0, ack_o}, 32'd0);
    check("rst strobe err",  {31'd0, err_o}, 32'd0);
    check("rst strobe data", data_o, 32'd0);
    model_reset();
    rst_i = 1'b0;
    @(posedge clk);
    #1;
`ifdef CELLRV32_SYSINFO_UPTIME_EN
    bus(BASE + 32'h44, 1'b1, 1'b0, 4'h0, '0);
    check("post-reset lo ack", {31'd0, last_ack}, 32'd1);
    check("post-reset lo", last_rd, 32'd1);
`else
    access("post-reset lo off", BASE + 32'h44, 1'b1, 1'b0, 4'h0, '0);
`endif
    access("post-reset ctrl", BASE + 32'h40, 1'b1, 1'b0, 4'h0, '0);
    check("post-reset lock", last_rd, 32'd0);
    access("post-reset scr0", BASE + 32'h60, 1'b1, 1'b0, 4'h0, '0);
    check("post-reset scr0 value", last_rd, 32'd0);
    access("post-reset scr3 write", BASE + 32'h6C, 1'b0, 1'b1, 4'b1100, 32'hBEEF0000);
    check("post-reset write ack", {31'd0, last_ack}, 32'd1);
    access("post-reset scr3 read", BASE + 32'h6C, 1'b1, 1'b0, 4'h0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
